// File: rtl/arbitro_rr2_8bits.sv
// Two-lane round-robin arbiter: each lane buffers bytes in its own FIFO and the
// grant FSM serialises them onto one output lane, alternating under contention.
module arbitro_rr2_8bits #(
    parameter int DEPTH  = 4,
    parameter int AF_LVL = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       push_0,
    input  logic [7:0] data_in_0,
    input  logic       push_1,
    input  logic [7:0] data_in_1,
    input  logic       pause,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_out,
    output logic       full_0,
    output logic       full_1,
    output logic       almost_full_0,
    output logic       almost_full_1,
    output logic       empty_0,
    output logic       empty_1,
    output logic       err_0,
    output logic       err_1
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);

    typedef enum logic [1:0] {IDLE, SERV0, SERV1} state_t;

    state_t state, state_next;
    logic   last_grant;

    logic [7:0]    mem_0 [DEPTH];
    logic [7:0]    mem_1 [DEPTH];
    logic [PW-1:0] wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
    logic [CW-1:0] count_0, count_1;
    logic          pop_0, pop_1, wr_0, wr_1;

    assign full_0        = (count_0 == FULL_CNT);
    assign full_1        = (count_1 == FULL_CNT);
    assign almost_full_0 = (count_0 >= AF_CNT);
    assign almost_full_1 = (count_1 >= AF_CNT);
    assign empty_0       = (count_0 == '0);
    assign empty_1       = (count_1 == '0);

    // A word is only visible through the registered count, so nothing falls through.
    always_comb begin
        pop_0      = 1'b0;
        pop_1      = 1'b0;
        state_next = IDLE;
        if (!pause) begin
            if (!empty_0 && !empty_1) begin
                if (last_grant) pop_0 = 1'b1;
                else            pop_1 = 1'b1;
            end else if (!empty_0) begin
                pop_0 = 1'b1;
            end else if (!empty_1) begin
                pop_1 = 1'b1;
            end
        end
        if (pop_0)      state_next = SERV0;
        else if (pop_1) state_next = SERV1;
    end

    // A push into a full FIFO still fits when the same edge frees the head slot.
    assign wr_0 = push_0 && (!full_0 || pop_0);
    assign wr_1 = push_1 && (!full_1 || pop_1);

    always_ff @(posedge clk_4f) begin
        if (wr_0) mem_0[wr_ptr_0] <= data_in_0;
        if (wr_1) mem_1[wr_ptr_1] <= data_in_1;
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            wr_ptr_0 <= '0;
            rd_ptr_0 <= '0;
            count_0  <= '0;
            err_0    <= 1'b0;
        end else begin
            if (wr_0) wr_ptr_0 <= wr_ptr_0 + PW'(1);
            if (pop_0) rd_ptr_0 <= rd_ptr_0 + PW'(1);
            case ({wr_0, pop_0})
                2'b10:   count_0 <= count_0 + CW'(1);
                2'b01:   count_0 <= count_0 - CW'(1);
                default: count_0 <= count_0;
            endcase
            if (push_0 && full_0 && !pop_0) err_0 <= 1'b1;
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            wr_ptr_1 <= '0;
            rd_ptr_1 <= '0;
            count_1  <= '0;
            err_1    <= 1'b0;
        end else begin
            if (wr_1) wr_ptr_1 <= wr_ptr_1 + PW'(1);
            if (pop_1) rd_ptr_1 <= rd_ptr_1 + PW'(1);
            case ({wr_1, pop_1})
                2'b10:   count_1 <= count_1 + CW'(1);
                2'b01:   count_1 <= count_1 - CW'(1);
                default: count_1 <= count_1;
            endcase
            if (push_1 && full_1 && !pop_1) err_1 <= 1'b1;
        end
    end

    // last_grant starts at 1 so lane 0 wins the first contention after reset.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            data_out   <= 8'h00;
            lane_out   <= 1'b0;
        end else begin
            state <= state_next;
            if (pop_0) begin
                data_out   <= mem_0[rd_ptr_0];
                lane_out   <= 1'b0;
                last_grant <= 1'b0;
            end else if (pop_1) begin
                data_out   <= mem_1[rd_ptr_1];
                lane_out   <= 1'b1;
                last_grant <= 1'b1;
            end
        end
    end

    assign valid_out = (state != IDLE);

endmodule

// File: tb/tb_arbitro_rr2_8bits.sv
// Directed self-checking bench for arbitro_rr2_8bits (DEPTH=4, AF_LVL=3) with
// hand-computed expectations checked by immediate assertions.
module tb_arbitro_rr2_8bits;

    logic       clk_4f;
    logic       reset;
    logic       push_0;
    logic [7:0] data_in_0;
    logic       push_1;
    logic [7:0] data_in_1;
    logic       pause;
    logic [7:0] data_out;
    logic       valid_out;
    logic       lane_out;
    logic       full_0, full_1;
    logic       almost_full_0, almost_full_1;
    logic       empty_0, empty_1;
    logic       err_0, err_1;

    int n_checks = 0;
    int n_pass   = 0;

    arbitro_rr2_8bits #(.DEPTH(4), .AF_LVL(3)) dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .push_0        (push_0),
        .data_in_0     (data_in_0),
        .push_1        (push_1),
        .data_in_1     (data_in_1),
        .pause         (pause),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .lane_out      (lane_out),
        .full_0        (full_0),
        .full_1        (full_1),
        .almost_full_0 (almost_full_0),
        .almost_full_1 (almost_full_1),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .err_0         (err_0),
        .err_1         (err_1)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic apply_stimulus(input logic p0, input logic [7:0] d0,
                                  input logic p1, input logic [7:0] d1,
                                  input logic ps);
        push_0    = p0;
        data_in_0 = d0;
        push_1    = p1;
        data_in_1 = d1;
        pause     = ps;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic check_word(input string tag, input logic v, input logic [7:0] d,
                              input logic l);
        check_output({tag, " valid"}, 32'(valid_out), 32'(v));
        check_output({tag, " data"},  32'(data_out),  32'(d));
        check_output({tag, " lane"},  32'(lane_out),  32'(l));
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        tick();

        // Reset values
        check_word("rst", 1'b0, 8'h00, 1'b0);
        check_output("rst empty_0", 32'(empty_0), 32'd1);
        check_output("rst empty_1", 32'(empty_1), 32'd1);
        check_output("rst full_0", 32'(full_0), 32'd0);
        check_output("rst af_1", 32'(almost_full_1), 32'd0);
        check_output("rst err_1", 32'(err_1), 32'd0);
        reset = 1'b0;

        // Two words per lane loaded together, then drained alternately from lane 0
        apply_stimulus(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
        tick();
        apply_stimulus(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
        tick();
        check_output("alt paused valid", 32'(valid_out), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick(); check_word("alt w0", 1'b1, 8'hA0, 1'b0);
        tick(); check_word("alt w1", 1'b1, 8'hB0, 1'b1);
        tick(); check_word("alt w2", 1'b1, 8'hA1, 1'b0);
        tick(); check_word("alt w3", 1'b1, 8'hB1, 1'b1);
        tick(); check_word("alt idle", 1'b0, 8'hB1, 1'b1);
        check_output("alt empty_0", 32'(empty_0), 32'd1);
        check_output("alt empty_1", 32'(empty_1), 32'd1);

        // Overfill lane 0 while paused: fifth word dropped, err_0 sticky
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00, 1'b1);
            tick();
            check_output($sformatf("ovf af_0 #%0d", i + 1), 32'(almost_full_0), 32'(i >= 2));
            check_output($sformatf("ovf full_0 #%0d", i + 1), 32'(full_0), 32'(i >= 3));
            check_output($sformatf("ovf err_0 #%0d", i + 1), 32'(err_0), 32'(i >= 4));
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_word($sformatf("ovf drain %0d", i), 1'b1, 8'h10 + 8'(i), 1'b0);
        end
        tick();
        check_word("ovf idle", 1'b0, 8'h13, 1'b0);
        check_output("ovf err sticky", 32'(err_0), 32'd1);

        // Clear err_0, fill lane 0, then push and pop together for 12 words
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("rst2 err_0", 32'(err_0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 8'h20 + 8'(i), 1'b0, 8'h00, 1'b1);
            tick();
        end
        check_output("wrap full_0 pre", 32'(full_0), 32'd1);
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 8'h24 + 8'(i), 1'b0, 8'h00, 1'b0);
            tick();
            check_word($sformatf("wrap pp %0d", i), 1'b1, 8'h20 + 8'(i), 1'b0);
            check_output($sformatf("wrap full_0 %0d", i), 32'(full_0), 32'd1);
            check_output($sformatf("wrap err_0 %0d", i), 32'(err_0), 32'd0);
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_word($sformatf("wrap drain %0d", i), 1'b1, 8'h2C + 8'(i), 1'b0);
        end
        tick();
        check_word("wrap idle", 1'b0, 8'h2F, 1'b0);
        check_output("wrap empty_0", 32'(empty_0), 32'd1);

        // Alternating traffic with a 3-cycle pause; last_grant is 0 here so lane 1 leads
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'hC0 + 8'(i), 1'b1, 8'hD0 + 8'(i), 1'b1);
            tick();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick(); check_word("pz w0", 1'b1, 8'hD0, 1'b1);
        tick(); check_word("pz w1", 1'b1, 8'hC0, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_word($sformatf("pz hold %0d", i), 1'b0, 8'hC0, 1'b0);
        end
        pause = 1'b0;
        tick(); check_word("pz w2", 1'b1, 8'hD1, 1'b1);
        tick(); check_word("pz w3", 1'b1, 8'hC1, 1'b0);
        tick(); check_word("pz w4", 1'b1, 8'hD2, 1'b1);
        tick(); check_word("pz w5", 1'b1, 8'hC2, 1'b0);
        tick(); check_word("pz idle", 1'b0, 8'hC2, 1'b0);

        // Asynchronous reset mid-cycle with two words still queued in lane 1
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, 8'hE0 + 8'(i), 1'b1);
            tick();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check_word("ar pre", 1'b1, 8'hE0, 1'b1);
        #3;
        reset = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b1, 8'h99, 1'b0);
        #1;
        check_word("ar async", 1'b0, 8'h00, 1'b0);
        check_output("ar async empty_1", 32'(empty_1), 32'd1);
        tick();
        tick();
        check_output("ar held empty_1", 32'(empty_1), 32'd1);
        reset = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_word($sformatf("ar quiet %0d", i), 1'b0, 8'h00, 1'b0);
        end
        check_output("ar empty_1", 32'(empty_1), 32'd1);

        // Lane 1 only: three back-to-back words
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1, 8'hF0 + 8'(i), 1'b1);
            tick();
        end
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_word($sformatf("l1 w%0d", i), 1'b1, 8'hF0 + 8'(i), 1'b1);
        end
        tick();
        check_word("l1 idle", 1'b0, 8'hF2, 1'b1);

        // A word written at an edge is not issued in the same cycle
        apply_stimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
        tick();
        check_word("nft write", 1'b0, 8'hF2, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check_word("nft issue", 1'b1, 8'h55, 1'b0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
